// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..width-1 and never be zero bits wide.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder composed of two half-adder stages and an OR for carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    assign p    = a ^ b;
    assign g    = a & b;
    assign s    = p ^ cin;
    assign t    = p & cin;
    assign cout = g | t;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// and reports {cout,sum} with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             c_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // NOTE: the default assignment comes first so no path leaves psum_next
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        psum_next            = psum >> 1;
        psum_next[WIDTH-1]   = s_bit;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        psum  <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_bit;
                    psum  <= psum_next;
                    if (cnt == LAST) begin
                        // Hold the counter on the final bit so it never wraps.
                        sum   <= psum_next;
                        cout  <= c_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random
// operands checked against plain-arithmetic addition, for WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic start1;
    logic a1;
    logic b1;
    logic busy1;
    logic done1;
    logic sum1;
    logic cout1;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at the first negedge inside RUN; returns at the negedge where
    // done is seen (or the bound expires).
    task automatic wait_done(input string tag, input logic [W:0] held,
                             output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 4 * W + 8) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == W / 2) check({tag, " sum_hold"}, {cout, sum}, held);
            @(negedge clk);
            lat++;
        end
        check({tag, " done_seen"}, done, 1'b1);
    endtask

    // Start at the current negedge; reference is plain (W+1)-bit addition.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [W:0] exp;
        logic [W:0] held;
        int lat;
        int busy_cnt;
        exp   = {1'b0, av} + {1'b0, bv};
        held  = {cout, sum};
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(tag, held, lat, busy_cnt);
        check({tag, " latency"}, lat, W);
        check({tag, " busy_cycles"}, busy_cnt, W);
        check({tag, " busy_with_done"}, busy, 1'b0);
        check({tag, " result"}, {cout, sum}, exp);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 1'b0);
        check({tag, " result_hold"}, {cout, sum}, exp);
    endtask

    task automatic run_w1(input logic av, input logic bv);
        logic [1:0] exp;
        exp    = {1'b0, av} + {1'b0, bv};
        a1     = av;
        b1     = bv;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1 busy_run", {busy1, done1}, 2'b10);
        @(negedge clk);
        check("w1 done", {busy1, done1}, 2'b01);
        check("w1 result", {cout1, sum1}, exp);
        @(negedge clk);
        check("w1 done_pulse", done1, 1'b0);
    endtask

    initial begin
        int lat;
        int busy_cnt;

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        #1;
        check("reset outputs", {busy, done, cout, sum}, '0);
        check("reset outputs w1", {busy1, done1, cout1, sum1}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases, starting on the first edge after reset.
        run_op(8'h00, 8'h00, "zero");
        run_op(8'hFF, 8'h01, "ff_plus_1");
        run_op(8'hFF, 8'hFF, "ff_plus_ff");
        run_op(8'hA5, 8'h5A, "a5_plus_5a");

        // Start held high, operands changed mid-run: first operands win,
        // then a second op begins only after passing through IDLE.
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(negedge clk);
        a     = 8'h77;
        b     = 8'h66;
        wait_done("held_start", {cout, sum}, lat, busy_cnt);
        check("held_start result", {cout, sum}, 9'h046);
        check("held_start latency", lat, W);
        @(negedge clk);
        check("held_start idle", {busy, done}, 2'b00);
        @(negedge clk);
        check("held_start restart", busy, 1'b1);
        start = 1'b0;
        wait_done("held_restart", {cout, sum}, lat, busy_cnt);
        check("held_restart result", {cout, sum}, 9'h0DD);
        @(negedge clk);

        // Reset in the 4th RUN cycle abandons the op and clears the result.
        a     = 8'h0F;
        b     = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset outputs", {busy, done, cout, sum}, '0);
        @(negedge clk);
        @(negedge clk);
        check("mid_reset no_done", done, 1'b0);
        rst_n = 1'b1;
        run_op(8'h03, 8'h04, "after_reset");

        // WIDTH=1 instance: all operand combinations.
        for (int i = 0; i < 4; i++) run_w1(i[0], i[1]);

        for (int i = 0; i < 16; i++) run_op(W'($urandom), W'($urandom), "random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
